// File: rtl/relm_uart_tx.sv
// relm_uart_tx: ReLM push-channel UART transmitter, 8N1, with a one-byte holding register.
module relm_uart_tx #(
  parameter int WD     = 32,
  parameter int CLKDIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  output logic        txd,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] RELOAD = 16'(CLKDIV - 1);
  state_t state_q, state_d;
  logic [7:0] hold_data_q, hold_data_d, shift_q, shift_d;
  logic hold_valid_q, hold_valid_d, txd_q, txd_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic accept, tick, load;
  logic unused_bits;
  assign unused_bits = ^push_d[WD-1:8];
  always_comb begin
    accept = push_d[WD] && !hold_valid_q;
    tick = (state_q != IDLE) && (baud_q == 16'd0);
    // the shifter takes the held byte from IDLE, or straight out of STOP for back-to-back frames
    load = hold_valid_q && (state_q == IDLE || (state_q == STOP && tick));
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    txd_d = txd_q;
    baud_d = (state_q == IDLE) ? baud_q : (tick ? RELOAD : baud_q - 16'd1);
    hold_data_d = accept ? push_d[7:0] : hold_data_q;
    hold_valid_d = accept | (hold_valid_q & ~load);
    if (load) begin
      state_d = START;
      shift_d = hold_data_q;
      baud_d = RELOAD;
      txd_d = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        START: begin
          state_d = DATA;
          bit_d = 3'd0;
          txd_d = shift_q[0];
        end
        DATA: begin
          shift_d = shift_q >> 1;
          bit_d = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? STOP : DATA;
          txd_d = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
        end
        STOP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_data_q <= 8'd0;
      hold_valid_q <= 1'b0;
      shift_q <= 8'd0;
      baud_q <= 16'd0;
      bit_q <= 3'd0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_data_q <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      shift_q <= shift_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      txd_q <= txd_d;
    end
  end
  assign push_retry = hold_valid_q;
  assign txd = txd_q;
  assign busy = (state_q != IDLE) || hold_valid_q;
endmodule
